// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage. Runs byte-serial loads/stores to an 8-bit
//            memory controller and passes non-memory results straight through.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int         ADDR_W   = 32,
  parameter logic [6:0] LOAD_OP  = 7'b0000011,
  parameter logic [6:0] STORE_OP = 7'b0100011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       data_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req_o,
  output logic              mc_req_o,
  output logic              mc_we_o,
  output logic [ADDR_W-1:0] mc_addr_o,
  output logic [7:0]        mc_wdata_o,
  input  logic              mc_ack_i,
  input  logic [7:0]        mc_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_k;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [31:0]       r_buf;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_size_ok;
  logic              w_mem_go;
  logic [1:0]        w_last_k;
  logic [ADDR_W-1:0] w_kaddr;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_ext;

  assign w_is_load  = (opcode_i == LOAD_OP);
  assign w_is_store = (opcode_i == STORE_OP);

  always_comb begin
    w_size_ok = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_size_ok = 1'b1;
      default:                                w_size_ok = 1'b0;
    endcase
  end

  assign w_mem_go = (w_is_load | w_is_store) & w_size_ok;

  // Index of the final byte: funct3[1:0] encodes the access size.
  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_last_k = 2'd0;
      2'b01:   w_last_k = 2'd1;
      default: w_last_k = 2'd3;
    endcase
  end

  assign w_kaddr = r_addr + {{(ADDR_W-2){1'b0}}, r_k};
  assign w_wbyte = r_data[{r_k, 3'b000} +: 8];

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{r_buf[7]}}, r_buf[7:0]};
      3'b001:  w_ext = {{16{r_buf[15]}}, r_buf[15:0]};
      3'b100:  w_ext = {24'h0, r_buf[7:0]};
      3'b101:  w_ext = {16'h0, r_buf[15:0]};
      default: w_ext = r_buf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // EX/MEM inputs are held by the stall, so they are captured only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= 2'd0;
      r_addr   <= '0;
      r_data   <= 32'h0;
      r_funct3 <= 3'b000;
      r_we     <= 1'b0;
      r_buf    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_go) begin
            r_k      <= 2'd0;
            r_addr   <= mem_addr_i;
            r_data   <= data_i;
            r_funct3 <= funct3_i;
            r_we     <= w_is_store;
            r_buf    <= 32'h0;
          end
        end
        S_ACCESS: begin
          if (mc_ack_i) begin
            if (!r_we) begin
              r_buf[{r_k, 3'b000} +: 8] <= mc_rdata_i;
            end
            r_k <= r_k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'h0;
    stall_req_o = 1'b0;
    mc_req_o    = 1'b0;
    mc_we_o     = 1'b0;
    mc_addr_o   = '0;
    mc_wdata_o  = 8'h0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_go) begin
          stall_req_o = 1'b1;
          w_next      = S_ACCESS;
        end else if (w_is_load | w_is_store) begin
          wd_o = wd_i;
        end else begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = data_i;
        end
      end
      S_ACCESS: begin
        stall_req_o = 1'b1;
        mc_req_o    = 1'b1;
        mc_we_o     = r_we;
        mc_addr_o   = w_kaddr;
        mc_wdata_o  = w_wbyte;
        if (mc_ack_i && (r_k == w_last_k)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
        wd_o   = wd_i;
        if (!r_we) begin
          wreg_o  = wreg_i;
          wdata_o = w_ext;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Outputs are forced quiet for as long as reset is held.
    if (rst) begin
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      wdata_o     = 32'h0;
      stall_req_o = 1'b0;
      mc_req_o    = 1'b0;
      mc_we_o     = 1'b0;
      mc_addr_o   = '0;
      mc_wdata_o  = 8'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Scoreboard bench for mem_stage with a byte-wide memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam logic [6:0] C_LOAD  = 7'b0000011;
  localparam logic [6:0] C_STORE = 7'b0100011;
  localparam logic [6:0] C_ADD   = 7'b0110011;
  localparam logic [6:0] C_NOP   = 7'b0010011;

  logic        clk;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] data_i;
  logic [31:0] mem_addr_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic        mc_req_o;
  logic        mc_we_o;
  logic [31:0] mc_addr_o;
  logic [7:0]  mc_wdata_o;
  logic        mc_ack_i;
  logic [7:0]  mc_rdata_i;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .opcode_i(opcode_i),
    .funct3_i(funct3_i), .data_i(data_i), .mem_addr_i(mem_addr_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
    .mc_req_o(mc_req_o), .mc_we_o(mc_we_o), .mc_addr_o(mc_addr_o),
    .mc_wdata_o(mc_wdata_o), .mc_ack_i(mc_ack_i), .mc_rdata_i(mc_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  typedef struct packed {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } wb_t;

  txn_t       exp_q[$];
  wb_t        wb_q[$];
  logic [7:0] tbmem [logic [31:0]];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    return tbmem.exists(a) ? tbmem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic drive_nop();
    opcode_i = C_NOP;
    funct3_i = 3'b000;
    mc_ack_i = 1'b0;
  endtask

  task automatic pass_thru(input logic [31:0] data, input logic [4:0] wd, input logic wreg);
    @(posedge clk); #1;
    opcode_i = C_ADD; funct3_i = 3'b000; data_i = data; wd_i = wd; wreg_i = wreg;
    mc_ack_i = 1'b1;
    #1;
    check("pass_wdata", wdata_o, data);
    check("pass_wd", wd_o, wd);
    check("pass_wreg", wreg_o, wreg);
    check("pass_stall", stall_req_o, 1'b0);
    check("pass_mcreq", mc_req_o, 1'b0);
    mc_ack_i = 1'b0;
  endtask

  // One load/store; acks on byte wait_k are withheld for wait_n cycles.
  task automatic issue(input logic is_store, input logic [2:0] f3, input logic [31:0] data,
                       input logic [31:0] addr, input logic [4:0] wd,
                       input int wait_k, input int wait_n);
    int          n;
    int          cyc;
    int          waited;
    int          idx;
    bit          done;
    logic [31:0] v;
    txn_t        t;
    wb_t         w;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      t.we    = is_store;
      t.addr  = addr + i;
      t.wdata = is_store ? data[8*i +: 8] : 8'h00;
      exp_q.push_back(t);
      if (!is_store) v[8*i +: 8] = rd(addr + i);
    end
    w.wreg  = ~is_store;
    w.wd    = wd;
    w.wdata = is_store ? 32'h0 : extend(f3, v);
    wb_q.push_back(w);

    @(posedge clk); #1;
    opcode_i = is_store ? C_STORE : C_LOAD;
    funct3_i = f3; data_i = data; mem_addr_i = addr; wd_i = wd; wreg_i = 1'b1;
    #4;
    check("idle_stall", stall_req_o, 1'b1);
    check("idle_wreg", wreg_o, 1'b0);
    check("idle_mcreq", mc_req_o, 1'b0);
    cyc = 1; waited = 0; done = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      idx = n - exp_q.size();
      if (idx == wait_k && waited < wait_n) begin
        mc_ack_i = 1'b0;
        waited++;
      end else begin
        mc_ack_i = 1'b1;
      end
      mc_rdata_i = (exp_q.size() > 0) ? rd(exp_q[0].addr) : 8'h00;
      #4;
      cyc++;
      if (stall_req_o) begin
        check("acc_mcreq", mc_req_o, 1'b1);
        check("acc_wreg", wreg_o, 1'b0);
        if (exp_q.size() == 0) begin
          check("acc_extra_byte", 1'b1, 1'b0);
          done = 1;
        end else begin
          t = exp_q[0];
          check("acc_addr", mc_addr_o, t.addr);
          check("acc_we", mc_we_o, t.we);
          if (t.we) check("acc_wdata", mc_wdata_o, t.wdata);
          if (mc_ack_i) begin
            void'(exp_q.pop_front());
            if (t.we) tbmem[t.addr] = t.wdata;
          end
        end
      end else begin
        done = 1;
        w = wb_q.pop_front();
        check("done_wreg", wreg_o, w.wreg);
        check("done_wdata", wdata_o, w.wdata);
        if (w.wreg) check("done_wd", wd_o, w.wd);
        check("done_mcreq", mc_req_o, 1'b0);
        check("latency", cyc, n + 2 + wait_n);
        check("bytes_left", exp_q.size(), 0);
        drive_nop();
      end
    end
    if (!done) begin
      check("timeout", 1'b0, 1'b1);
      exp_q.delete();
      wb_q.delete();
      drive_nop();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wd_i = 5'd9; wreg_i = 1'b1; opcode_i = C_NOP; funct3_i = 3'b000;
    data_i = 32'hDEAD; mem_addr_i = 32'h0; mc_ack_i = 1'b0; mc_rdata_i = 8'h0;
    tbmem[32'h100] = 8'h78; tbmem[32'h101] = 8'h56;
    tbmem[32'h102] = 8'h34; tbmem[32'h103] = 8'h12;
    tbmem[32'h7]   = 8'h80;
    tbmem[32'h301] = 8'hFE; tbmem[32'h302] = 8'h80;
    repeat (2) @(posedge clk);
    #5;
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_wreg", wreg_o, 1'b0);
    check("rst_wd", wd_o, 5'd0);
    check("rst_stall", stall_req_o, 1'b0);
    check("rst_mcreq", mc_req_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    pass_thru(32'h1234, 5'd5, 1'b1);
    pass_thru(32'hFFFF_0001, 5'd31, 1'b0);

    @(posedge clk); #1;
    opcode_i = C_LOAD; funct3_i = 3'b011; wreg_i = 1'b1;
    #4;
    check("badf3_stall", stall_req_o, 1'b0);
    check("badf3_wreg", wreg_o, 1'b0);
    check("badf3_mcreq", mc_req_o, 1'b0);
    @(posedge clk); #5;
    check("badf3_mcreq2", mc_req_o, 1'b0);
    drive_nop();

    issue(1'b0, 3'b010, 32'h0, 32'h100, 5'd1, -1, 0);
    issue(1'b0, 3'b000, 32'h0, 32'h7, 5'd2, -1, 0);
    issue(1'b0, 3'b100, 32'h0, 32'h7, 5'd3, -1, 0);
    issue(1'b0, 3'b001, 32'h0, 32'h301, 5'd4, -1, 0);
    issue(1'b0, 3'b101, 32'h0, 32'h301, 5'd6, -1, 0);
    issue(1'b1, 3'b001, 32'hAABBCCDD, 32'hFFFF_FFFF, 5'd7, -1, 0);
    issue(1'b0, 3'b101, 32'h0, 32'hFFFF_FFFF, 5'd8, -1, 0);
    issue(1'b0, 3'b010, 32'h0, 32'h100, 5'd10, 1, 3);
    issue(1'b1, 3'b000, 32'h0000_00A5, 32'h400, 5'd11, 0, 2);
    issue(1'b0, 3'b000, 32'h0, 32'h400, 5'd12, -1, 0);

    // SW aborted by reset after its second byte has been accepted.
    @(posedge clk); #1;
    opcode_i = C_STORE; funct3_i = 3'b010; data_i = 32'hCAFEF00D;
    mem_addr_i = 32'h200; wd_i = 5'd13; mc_ack_i = 1'b1;
    @(posedge clk); #5;
    check("abort_b0_addr", mc_addr_o, 32'h200);
    tbmem[32'h200] = 8'h0D;
    @(posedge clk); #5;
    check("abort_b1_addr", mc_addr_o, 32'h201);
    tbmem[32'h201] = 8'hF0;
    @(posedge clk); #1;
    rst = 1'b1; mc_ack_i = 1'b0;
    @(posedge clk); #1;
    opcode_i = C_NOP;
    #4;
    check("abort_mcreq", mc_req_o, 1'b0);
    check("abort_stall", stall_req_o, 1'b0);
    check("abort_outs", {wd_o, wreg_o, wdata_o, mc_we_o, mc_addr_o, mc_wdata_o}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #5;
      check("post_rst_mcreq", mc_req_o, 1'b0);
    end
    issue(1'b0, 3'b010, 32'h0, 32'h200, 5'd14, -1, 0);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
